// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them to consecutive word addresses and releases the CPU once the image is complete.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_run,
    output logic        busy,
    output logic        err,
    output logic [6:0]  words_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] DEPTH_W = 8'(DEPTH);

    state_t      state_q,      state_d;
    logic [6:0]  len_q,        len_d;
    logic [1:0]  byte_cnt_q,   byte_cnt_d;
    logic [23:0] partial_q,    partial_d;
    logic        in_ready_q,   in_ready_d;
    logic        mem_we_q,     mem_we_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [6:0]  words_done_q, words_done_d;

    logic        accept_s;
    logic        len_ok_s;
    logic        last_word_s;

    // in_ready_q is only ever set while in LOAD, so it alone qualifies a handshake
    assign accept_s    = in_valid & in_ready_q;
    assign len_ok_s    = (len != 7'd0) && ({1'b0, len} <= DEPTH_W);
    assign last_word_s = (words_done_q == 7'(len_q - 7'd1));

    // Next-state and datapath update for the load sequencer
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        partial_d    = partial_q;
        in_ready_d   = in_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        words_done_d = words_done_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    if (len_ok_s) begin
                        state_d      = ST_LOAD;
                        len_d        = len;
                        byte_cnt_d   = 2'd0;
                        partial_d    = 24'd0;
                        words_done_d = 7'd0;
                        in_ready_d   = 1'b1;
                    end else begin
                        state_d    = ST_ERR;
                        in_ready_d = 1'b0;
                    end
                end else begin
                    in_ready_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    if (byte_cnt_q == 2'd3) begin
                        // words_done_q still indexes this word; it advances on the write edge
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BASE_ADDR + {23'd0, words_done_q, 2'b00};
                        mem_wdata_d  = {partial_q, in_data};
                        words_done_d = 7'(words_done_q + 7'd1);
                        byte_cnt_d   = 2'd0;
                        partial_d    = 24'd0;
                        if (last_word_s) begin
                            in_ready_d = 1'b0;
                        end else begin
                            in_ready_d = 1'b1;
                        end
                    end else begin
                        partial_d  = {partial_q[15:0], in_data};
                        byte_cnt_d = 2'(byte_cnt_q + 2'd1);
                    end
                end else begin
                    partial_d = partial_q;
                end
                if (mem_we_q && (words_done_q == len_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so a mid-load reset drops any partial word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= 7'd0;
            byte_cnt_q   <= 2'd0;
            partial_q    <= 24'd0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            words_done_q <= 7'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            partial_q    <= partial_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            words_done_q <= words_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign words_done = words_done_q;
    assign busy       = (state_q == ST_LOAD);
    assign err        = (state_q == ST_ERR);
    assign cpu_run    = (state_q == ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are sent
// and popped by a monitor whenever mem_we is seen.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        err;
    logic [6:0]  words_done;

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(BASE), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .err(err), .words_done(words_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] wd;
    } wr_t;

    wr_t sb_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;
    int  wr_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("wr_addr", mem_addr, mon_e.addr);
                check_eq("wr_data", mem_wdata, mon_e.data);
                check_eq("wr_words_done", {25'd0, words_done}, mon_e.wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic rdy;
        bit   got;
        got = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
        end
        in_valid = 1'b0;
        if (!got) check_eq("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int k, input bit gap);
        logic [7:0] b;
        wr_t        e;
        for (int j = 0; j < 4; j++) begin
            b = w[31-8*j -: 8];
            send_byte(b, gap);
        end
        e.addr = BASE + 32'(k * 4);
        e.data = w;
        e.wd   = 32'(k + 1);
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_run === 1'b1) seen = 1'b1;
        end
        check_eq(tag, {31'd0, cpu_run}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, {27'd0, in_ready, mem_we, cpu_run, busy, err}, 32'd0);
        check_eq({tag, "_addr"}, mem_addr, 32'd0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
        check_eq({tag, "_wd"}, {25'd0, words_done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w0;
        logic [31:0] rw;
        reset = 1'b0; start = 1'b0; len = 7'd0; in_valid = 1'b0; in_data = 8'd0;
        #2;
        check_reset_outputs("reset");
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Back-to-back two-word load with exact completion timing
        do_start(7'd2);
        check_eq("busy_load", {31'd0, busy}, 32'd1);
        check_eq("ready_load", {31'd0, in_ready}, 32'd1);
        w0 = wr_cnt;
        send_word(32'h2008_0005, 0, 1'b0);
        send_word(32'h23BD_FFFC, 1, 1'b0);
        check_eq("ready_after_last", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_eq("we_cycle", {30'd0, mem_we, cpu_run}, 32'd2);
        @(negedge clk);
        check_eq("run_cycle", {29'd0, mem_we, cpu_run, busy}, 32'd2);
        check_eq("words_done_2", {25'd0, words_done}, 32'd2);
        check_eq("writes_t1", 32'(wr_cnt - w0), 32'd2);
        check_eq("hold_addr", mem_addr, 32'h0000_0004);
        check_eq("hold_data", mem_wdata, 32'h23BD_FFFC);
        tick();

        // Same stream with idle cycles between bytes, restarted from DONE
        do_start(7'd2);
        check_eq("run_drop", {31'd0, cpu_run}, 32'd0);
        check_eq("wd_cleared", {25'd0, words_done}, 32'd0);
        w0 = wr_cnt;
        send_word(32'h2008_0005, 0, 1'b1);
        send_word(32'h23BD_FFFC, 1, 1'b1);
        wait_done("done_gap");
        check_eq("writes_gap", 32'(wr_cnt - w0), 32'd2);
        tick();

        // Zero length goes to ERR without writing; a valid start recovers
        w0 = wr_cnt;
        do_start(7'd0);
        check_eq("err_len0", {30'd0, err, cpu_run}, 32'd2);
        check_eq("wd_hold_err", {25'd0, words_done}, 32'd2);
        repeat (2) tick();
        check_eq("writes_len0", 32'(wr_cnt - w0), 32'd0);
        do_start(7'd1);
        check_eq("err_clear", {30'd0, err, busy}, 32'd1);
        send_word(32'h0000_0000, 0, 1'b0);
        wait_done("done_zero");
        check_eq("writes_zero", 32'(wr_cnt - w0), 32'd1);
        tick();

        // Oversize length is rejected
        w0 = wr_cnt;
        do_start(7'd65);
        check_eq("err_len65", {30'd0, err, busy}, 32'd2);
        repeat (2) tick();
        check_eq("writes_len65", 32'(wr_cnt - w0), 32'd0);

        // Asynchronous reset in the middle of a word
        do_start(7'd1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset = 1'b0;
        #2;
        check_reset_outputs("midreset");
        tick();
        reset = 1'b1;
        tick();
        w0 = wr_cnt;
        do_start(7'd1);
        send_word(32'hAABB_CCDD, 0, 1'b0);
        wait_done("done_after_reset");
        check_eq("writes_after_reset", 32'(wr_cnt - w0), 32'd1);
        tick();

        // Full-depth load, then a surplus byte that must be refused
        w0 = wr_cnt;
        do_start(7'd64);
        for (int k = 0; k < 64; k++) begin
            rw = $urandom();
            send_word(rw, k, 1'b0);
        end
        check_eq("ready_after_256", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("ready_257", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        wait_done("done_full");
        check_eq("writes_full", 32'(wr_cnt - w0), 32'd64);
        check_eq("last_addr", mem_addr, 32'h0000_00FC);
        check_eq("wd_full", {25'd0, words_done}, 32'd64);
        tick();

        // Start during LOAD is ignored
        w0 = wr_cnt;
        do_start(7'd2);
        send_word(32'h1234_5678, 0, 1'b0);
        do_start(7'd5);
        check_eq("busy_ignore", {31'd0, busy}, 32'd1);
        send_word(32'h9ABC_DEF0, 1, 1'b0);
        wait_done("done_ignore");
        check_eq("writes_ignore", 32'(wr_cnt - w0), 32'd2);
        check_eq("wd_ignore", {25'd0, words_done}, 32'd2);
        repeat (3) tick();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
